// File: rtl/gate_truth_sequencer.sv
// gate_truth_sequencer
// Clocked truth-table sweeper for a small combinational gate under test.
// Drives every input combination from all-zeros to all-ones, holds each
// row for SETTLE_CYCLES clocks, samples the gate output for one cycle,
// and accumulates the captured table, a mismatch count and the first
// failing row against the EXPECTED table. Results stay stable in DONE
// until the next accepted start or reset.
module gate_truth_sequencer #(
    parameter int                          N_INPUTS      = 2,
    parameter int                          SETTLE_CYCLES = 4,
    parameter logic [(2**N_INPUTS)-1:0]    EXPECTED      = 4'b1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic [N_INPUTS-1:0]         stim,
    input  logic                        dut_y,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [N_INPUTS:0]           err_count,
    output logic [N_INPUTS-1:0]         first_fail,
    output logic [(2**N_INPUTS)-1:0]    captured
);

    localparam int ROWS  = 2**N_INPUTS;
    // The settle counter only has to reach SETTLE_CYCLES-1.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] LAST_ROW    = N_INPUTS'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                  state_q,      state_d;
    logic [N_INPUTS-1:0]     row_q,        row_d;
    logic [CNT_W-1:0]        cnt_q,        cnt_d;
    logic                    busy_q,       busy_d;
    logic                    done_q,       done_d;
    logic                    pass_q,       pass_d;
    logic [N_INPUTS:0]       err_count_q,  err_count_d;
    logic [N_INPUTS-1:0]     first_fail_q, first_fail_d;
    logic [ROWS-1:0]         captured_q,   captured_d;
    logic                    fail_seen_q,  fail_seen_d;

    logic                    mismatch_s;
    logic [N_INPUTS:0]       err_next_s;

    // Reference value the gate should produce for a given row.
    function automatic logic expected_bit(input logic [N_INPUTS-1:0] row);
        return EXPECTED[row];
    endfunction

    // Next-state and next-result logic for the sweep FSM.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        captured_d   = captured_q;
        fail_seen_d  = fail_seen_q;
        mismatch_s   = 1'b0;
        err_next_s   = err_count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Accepting a start wipes the previous sweep's results.
                    state_d      = ST_SETTLE;
                    row_d        = '0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_count_d  = '0;
                    first_fail_d = '0;
                    captured_d   = '0;
                    fail_seen_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            ST_SAMPLE: begin
                captured_d[row_q] = dut_y;
                mismatch_s        = (dut_y != expected_bit(row_q));
                if (mismatch_s) begin
                    err_next_s = err_count_q + 1'b1;
                end else begin
                    err_next_s = err_count_q;
                end
                err_count_d = err_next_s;

                if (mismatch_s && !fail_seen_q) begin
                    first_fail_d = row_q;
                    fail_seen_d  = 1'b1;
                end else begin
                    first_fail_d = first_fail_q;
                end

                if (row_q == LAST_ROW) begin
                    // pass must reflect the count including this last row.
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_next_s == '0);
                end else begin
                    state_d = ST_SETTLE;
                    row_d   = row_q + 1'b1;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            first_fail_q <= '0;
            captured_q   <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
            captured_q   <= captured_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    // The row index is the stimulus, so stim only moves at row boundaries.
    assign stim       = row_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign first_fail = first_fail_q;
    assign captured   = captured_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: two instances (default 2-input/settle 4
// AND, and 3-input/settle 1 AND), table-driven sweeps, a mid-sweep reset
// sequence, and randomized gate tables checked against a reference model.
module tb_gate_truth_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_v;
    logic y_v;
    bit   sel;

    // Instance A: defaults
    logic       start_a, y_a;
    logic [1:0] stim_a;
    logic       busy_a, done_a, pass_a;
    logic [2:0] err_a;
    logic [1:0] ff_a;
    logic [3:0] cap_a;

    // Instance B: 3 inputs, settle 1
    logic       start_b, y_b;
    logic [2:0] stim_b;
    logic       busy_b, done_b, pass_b;
    logic [3:0] err_b;
    logic [2:0] ff_b;
    logic [7:0] cap_b;

    assign start_a = (sel == 1'b0) ? start_v : 1'b0;
    assign start_b = (sel == 1'b1) ? start_v : 1'b0;
    assign y_a     = y_v;
    assign y_b     = y_v;

    gate_truth_sequencer u_a (
        .clk(clk), .rst(rst), .start(start_a), .stim(stim_a), .dut_y(y_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail(ff_a), .captured(cap_a)
    );

    gate_truth_sequencer #(.N_INPUTS(3), .SETTLE_CYCLES(1), .EXPECTED(8'h80)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .stim(stim_b), .dut_y(y_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail(ff_b), .captured(cap_b)
    );

    logic [3:0]  o_stim;
    logic [4:0]  o_err;
    logic [3:0]  o_ff;
    logic [15:0] o_cap;
    logic        o_busy, o_done, o_pass;

    assign o_stim = sel ? {1'b0, stim_b} : {2'b00, stim_a};
    assign o_err  = sel ? {1'b0, err_b}  : {2'b00, err_a};
    assign o_ff   = sel ? {1'b0, ff_b}   : {2'b00, ff_a};
    assign o_cap  = sel ? {8'h00, cap_b} : {12'h000, cap_a};
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_pass = sel ? pass_b : pass_a;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".stim"}, o_stim, 0);
        chk({nm, ".busy"}, o_busy, 0);
        chk({nm, ".done"}, o_done, 0);
        chk({nm, ".pass"}, o_pass, 0);
        chk({nm, ".err"},  o_err,  0);
        chk({nm, ".ff"},   o_ff,   0);
        chk({nm, ".cap"},  o_cap,  0);
    endtask

    // Reference model: straight from the truth-table definition.
    task automatic model(input bit s, input logic [15:0] tbl,
                         output logic [15:0] cap, output int err,
                         output int ff, output bit pss);
        int          rows;
        logic [15:0] expv;
        bit          seen;
        rows = s ? 8 : 4;
        expv = s ? 16'h0080 : 16'h0008;
        seen = 1'b0;
        cap  = 16'h0000;
        err  = 0;
        ff   = 0;
        for (int r = 0; r < rows; r++) begin
            cap[r] = tbl[r];
            if (tbl[r] != expv[r]) begin
                err++;
                if (!seen) begin
                    ff   = r;
                    seen = 1'b1;
                end
            end
        end
        pss = (err == 0);
    endtask

    // One full sweep; start accepted at edge 0, inputs driven on negedges.
    task automatic sweep(input string nm, input bit s, input logic [15:0] tbl,
                         input bit noise, input int ign1, input int ign2,
                         input logic [15:0] e_cap, input int e_err,
                         input int e_ff, input bit e_pass);
        int per, rows, total, row;
        per   = s ? 2 : 5;
        rows  = s ? 8 : 4;
        total = rows * per;
        @(negedge clk);
        sel     = s;
        start_v = 1'b1;
        y_v     = 1'($urandom);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            row = (k - 1) / per;
            chk({nm, ".stim"}, o_stim, row);
            chk({nm, ".busy"}, o_busy, 1);
            chk({nm, ".done_early"}, o_done, 0);
            chk({nm, ".cap_partial"}, o_cap, e_cap & ((16'h1 << row) - 16'h1));
            if (k == 1) begin
                chk({nm, ".pass_clr"}, o_pass, 0);
                chk({nm, ".err_clr"},  o_err,  0);
                chk({nm, ".ff_clr"},   o_ff,   0);
            end
            start_v = (k == ign1) || (k == ign2);
            if ((k % per) == 0) y_v = tbl[k / per - 1];
            else if (noise)     y_v = 1'($urandom);
            else                y_v = tbl[row];
        end
        @(negedge clk);
        start_v = 1'b0;
        chk({nm, ".done"}, o_done, 1);
        chk({nm, ".busy_end"}, o_busy, 0);
        chk({nm, ".cap"},  o_cap,  e_cap);
        chk({nm, ".err"},  o_err,  e_err);
        chk({nm, ".ff"},   o_ff,   e_ff);
        chk({nm, ".pass"}, o_pass, e_pass);
        repeat (3) begin
            y_v = 1'($urandom);
            @(negedge clk);
            chk({nm, ".hold_done"}, o_done, 1);
            chk({nm, ".hold_cap"},  o_cap,  e_cap);
            chk({nm, ".hold_err"},  o_err,  e_err);
        end
    endtask

    typedef struct {
        bit          s;
        logic [15:0] tbl;
        bit          noise;
        int          ign1;
        int          ign2;
        logic [15:0] cap;
        int          err;
        int          ff;
        bit          pss;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [15:0] r_tbl, m_cap;
        int          m_err, m_ff, tot;
        bit          m_pass, r_s;

        vecs[0]  = '{1'b0, 16'h0008, 1'b0, -1, -1, 16'h0008, 0, 0, 1'b1};
        vecs[1]  = '{1'b0, 16'h000E, 1'b0, -1, -1, 16'h000E, 2, 1, 1'b0};
        vecs[2]  = '{1'b0, 16'h0008, 1'b0, -1, -1, 16'h0008, 0, 0, 1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, -1, -1, 16'h0000, 1, 3, 1'b0};
        vecs[4]  = '{1'b0, 16'h0008, 1'b0,  3,  8, 16'h0008, 0, 0, 1'b1};
        vecs[5]  = '{1'b0, 16'h0008, 1'b1, -1, -1, 16'h0008, 0, 0, 1'b1};
        vecs[6]  = '{1'b0, 16'h0009, 1'b0, -1, -1, 16'h0009, 1, 0, 1'b0};
        vecs[7]  = '{1'b0, 16'h0007, 1'b0, -1, -1, 16'h0007, 4, 0, 1'b0};
        vecs[8]  = '{1'b1, 16'h0080, 1'b0, -1, -1, 16'h0080, 0, 0, 1'b1};
        vecs[9]  = '{1'b1, 16'h0000, 1'b0, -1, -1, 16'h0000, 1, 7, 1'b0};
        vecs[10] = '{1'b1, 16'h00FE, 1'b0, -1, -1, 16'h00FE, 6, 1, 1'b0};
        vecs[11] = '{1'b1, 16'h0080, 1'b1,  1,  5, 16'h0080, 0, 0, 1'b1};

        // Reset with start held high: reset must win on both instances.
        rst     = 1'b1;
        start_v = 1'b1;
        y_v     = 1'b1;
        sel     = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset_a");
        sel = 1'b1;
        #1;
        chk_reset("reset_b");
        rst     = 1'b0;
        start_v = 1'b0;
        sel     = 1'b0;
        @(negedge clk);
        chk_reset("idle_a");

        for (int i = 0; i < 12; i++) begin
            sweep($sformatf("vec%0d", i), vecs[i].s, vecs[i].tbl, vecs[i].noise,
                  vecs[i].ign1, vecs[i].ign2, vecs[i].cap, vecs[i].err,
                  vecs[i].ff, vecs[i].pss);
        end

        // Reset during row 2, with start also high on that edge.
        @(negedge clk);
        sel     = 1'b0;
        start_v = 1'b1;
        y_v     = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start_v = 1'b0;
            if (k == 11) begin
                chk("midrst.pre_stim", o_stim, 2);
                chk("midrst.pre_cap",  o_cap,  16'h0003);
                chk("midrst.pre_err",  o_err,  2);
                rst     = 1'b1;
                start_v = 1'b1;
            end
        end
        @(negedge clk);
        rst     = 1'b0;
        start_v = 1'b0;
        chk_reset("midrst.post");
        @(negedge clk);
        chk_reset("midrst.idle");
        sweep("after_rst", 1'b0, 16'h0008, 1'b0, -1, -1, 16'h0008, 0, 0, 1'b1);

        // Randomized gate tables with random ignored start pulses.
        for (int i = 0; i < 16; i++) begin
            r_s   = 1'($urandom);
            r_tbl = 16'($urandom) & (r_s ? 16'h00FF : 16'h000F);
            tot   = r_s ? 16 : 20;
            model(r_s, r_tbl, m_cap, m_err, m_ff, m_pass);
            sweep($sformatf("rand%0d", i), r_s, r_tbl, 1'($urandom),
                  int'($urandom_range(1, tot)), int'($urandom_range(1, tot)),
                  m_cap, m_err, m_ff, m_pass);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
